// File: rtl/rv32i_exu_alu_imm_pkg.sv
// Shared definitions for the RV32I execute-stage ALU/immediate slice.
// Contents: datapath width, major opcodes, funct3 codes for ALU and
// branch operations, the canonical NOP, and small field-extract helpers.
package rv32i_exu_alu_imm_pkg;

  localparam int XLEN = 32;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  // ALU funct3 codes (OP / OP_IMM)
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // add x0,x0,x0: used by the core to flush the E stage
  localparam logic [31:0] NOP = 32'h0000_0033;

  function automatic logic [6:0] get_opcode(input logic [31:0] inst);
    return inst[6:0];
  endfunction

  function automatic logic [2:0] get_funct3(input logic [31:0] inst);
    return inst[14:12];
  endfunction

endpackage

// File: rtl/rv32i_exu_alu_imm_if.sv
// Bus between the core's E stage and the ALU/immediate slice.
// Signals: inst, in_a, in_b (core -> slice); imm, result, take_b
// (combinational, slice -> core); imm_q, result_q, take_b_q (registered
// copies for the E/M boundary, slice -> core).
// master = core side, slave = ALU/immediate slice.
// There is no handshake: every field is valid every cycle; a flushed stage
// simply carries NOP.
interface rv32i_exu_alu_imm_if;
  import rv32i_exu_alu_imm_pkg::*;

  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] result;
  logic            take_b;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] result_q;
  logic            take_b_q;

  modport master (
    output inst, in_a, in_b,
    input  imm, result, take_b, imm_q, result_q, take_b_q
  );

  modport slave (
    input  inst, in_a, in_b,
    output imm, result, take_b, imm_q, result_q, take_b_q
  );

endinterface

// File: rtl/rv32i_imm_gen.sv
// RV32I immediate generator (purely combinational).
// Ports: inst_i (32) instruction word; imm_o (32) decoded, sign-extended
// immediate. R-type and unrecognised opcodes produce 0.
module rv32i_imm_gen
  import rv32i_exu_alu_imm_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [31:0] imm_o
);

  logic [6:0] opcode;
  assign opcode = get_opcode(inst_i);

  always_comb begin
    imm_o = '0;
    case (opcode)
      LOAD, OP_IMM, JALR, SYSTEM:
        imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      STORE:
        imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      BRANCH:
        imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                 inst_i[11:8], 1'b0};
      LUI, AUIPC:
        imm_o = {inst_i[31:12], 12'b0};
      JAL:
        imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                 inst_i[30:21], 1'b0};
      default:
        imm_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_exu_alu_imm.sv
// RV32I execute-stage slice: immediate generator, integer ALU and branch
// condition evaluation, plus a one-cycle register stage for the E/M boundary.
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high; clears the registered outputs only
//   exu_if  slave side of rv32i_exu_alu_imm_if (inst/in_a/in_b in;
//           imm/result/take_b combinational out; *_q registered out)
module rv32i_exu_alu_imm
  import rv32i_exu_alu_imm_pkg::*;
#(
  parameter int XLEN_P = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  rv32i_exu_alu_imm_if.slave   exu_if
);

  // Only a 32-bit datapath is implemented.
  if (XLEN_P != XLEN) begin : g_bad_xlen
    $error("rv32i_exu_alu_imm: only XLEN_P=32 is supported");
  end

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            alt;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] result;
  logic            take_b;
  logic            lt_s;
  logic            lt_u;
  logic            eq;

  assign opcode = get_opcode(exu_if.inst);
  assign funct3 = get_funct3(exu_if.inst);
  assign alt    = exu_if.inst[30];
  assign in_a   = exu_if.in_a;
  assign in_b   = exu_if.in_b;
  assign shamt  = in_b[4:0];

  // Comparisons shared by SLT/SLTU and the branch unit.
  assign lt_s = $signed(in_a) < $signed(in_b);
  assign lt_u = in_a < in_b;
  assign eq   = in_a == in_b;

  rv32i_imm_gen u_imm_gen (
    .inst_i (exu_if.inst),
    .imm_o  (imm)
  );

  // ALU. Non-ALU opcodes fall through to a plain add, which the core uses
  // for link values (PC+4), AUIPC and address generation.
  always_comb begin
    result = in_a + in_b;
    if (opcode == OP || opcode == OP_IMM) begin
      case (funct3)
        // inst[30] on OP-IMM is an immediate bit, not a subtract select.
        F3_ADD:  result = (opcode == OP && alt) ? in_a - in_b : in_a + in_b;
        F3_SLL:  result = in_a << shamt;
        F3_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
        F3_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
        F3_XOR:  result = in_a ^ in_b;
        F3_SR:   result = alt ? $unsigned($signed(in_a) >>> shamt)
                              : in_a >> shamt;
        F3_OR:   result = in_a | in_b;
        F3_AND:  result = in_a & in_b;
        default: result = in_a + in_b;
      endcase
    end
  end

  // Branch condition; funct3 010/011 are not branches and never take.
  always_comb begin
    take_b = 1'b0;
    if (opcode == BRANCH) begin
      case (funct3)
        F3_BEQ:  take_b = eq;
        F3_BNE:  take_b = !eq;
        F3_BLT:  take_b = lt_s;
        F3_BGE:  take_b = !lt_s;
        F3_BLTU: take_b = lt_u;
        F3_BGEU: take_b = !lt_u;
        default: take_b = 1'b0;
      endcase
    end
  end

  assign exu_if.imm    = imm;
  assign exu_if.result = result;
  assign exu_if.take_b = take_b;

  // E/M register stage. No enable: the core flushes by inserting NOP.
  logic [XLEN-1:0] imm_d,    imm_q;
  logic [XLEN-1:0] result_d, result_q;
  logic            take_b_d, take_b_q;

  assign imm_d    = imm;
  assign result_d = result;
  assign take_b_d = take_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      imm_q    <= '0;
      result_q <= '0;
      take_b_q <= 1'b0;
    end else begin
      imm_q    <= imm_d;
      result_q <= result_d;
      take_b_q <= take_b_d;
    end
  end

  assign exu_if.imm_q    = imm_q;
  assign exu_if.result_q = result_q;
  assign exu_if.take_b_q = take_b_q;

endmodule

// File: tb/tb_rv32i_exu_alu_imm.sv
// Directed bench for rv32i_exu_alu_imm. The driver applies one vector per
// cycle on the falling edge and queues the hand-computed response; the
// monitor checks combinational and registered outputs after each rising edge.
module tb_rv32i_exu_alu_imm;
  import rv32i_exu_alu_imm_pkg::*;

  // Packed expectation: imm, result, take_b, imm_q, result_q, take_b_q
  localparam int W = 32 + 32 + 1 + 32 + 32 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv32i_exu_alu_imm_if bus ();

  rv32i_exu_alu_imm dut (
    .clk    (clk),
    .reset  (reset),
    .exu_if (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic         drv_valid;
  int           checks = 0;
  int           errors = 0;
  int           vec_no = 0;

  task automatic check32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] inst, input logic [31:0] a,
                       input logic [31:0] b, input logic rst,
                       input logic [31:0] e_imm, input logic [31:0] e_res,
                       input logic e_take);
    logic [31:0] q_imm;
    logic [31:0] q_res;
    logic        q_take;
    @(negedge clk);
    bus.inst  = inst;
    bus.in_a  = a;
    bus.in_b  = b;
    reset     = rst;
    drv_valid = 1'b1;
    q_imm  = rst ? 32'h0 : e_imm;
    q_res  = rst ? 32'h0 : e_res;
    q_take = rst ? 1'b0  : e_take;
    exp_q.push_back({e_imm, e_res, e_take, q_imm, q_res, q_take});
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (drv_valid) begin
        vec_no++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL v%0d queue: got empty expected entry", vec_no);
        end else begin
          e = exp_q.pop_front();
          check32($sformatf("v%0d imm", vec_no), bus.imm, e[129:98]);
          check32($sformatf("v%0d result", vec_no), bus.result, e[97:66]);
          check32($sformatf("v%0d take_b", vec_no), {31'b0, bus.take_b},
                  {31'b0, e[65]});
          check32($sformatf("v%0d imm_q", vec_no), bus.imm_q, e[64:33]);
          check32($sformatf("v%0d result_q", vec_no), bus.result_q, e[32:1]);
          check32($sformatf("v%0d take_b_q", vec_no), {31'b0, bus.take_b_q},
                  {31'b0, e[0]});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    drv_valid = 1'b0;
    bus.inst  = NOP;
    bus.in_a  = '0;
    bus.in_b  = '0;
    repeat (2) @(posedge clk);

    //     inst          in_a          in_b          rst   imm           result        take
    // Reset state, then reset holding while the ALU still computes.
    drive(NOP,          32'h0,        32'h0,        1'b1, 32'h0,        32'h0,        1'b0);
    drive(NOP,          32'h11,       32'h22,       1'b1, 32'h0,        32'h33,       1'b0);
    // ADDI -1; ADDI with inst[30] set must still add.
    drive(32'hFFF00093, 32'h5,        32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'h4,        1'b0);
    drive(32'h40000093, 32'h1,        32'h400,      1'b0, 32'h400,      32'h401,      1'b0);
    // SUB / ADD
    drive(32'h40208033, 32'h3,        32'h5,        1'b0, 32'h0,        32'hFFFFFFFE, 1'b0);
    drive(32'h00208033, 32'h3,        32'h5,        1'b0, 32'h0,        32'h8,        1'b0);
    // SRAI / SRLI by 4
    drive(32'h4040D093, 32'h80000000, 32'h404,      1'b0, 32'h404,      32'hF8000000, 1'b0);
    drive(32'h0040D093, 32'h80000000, 32'h4,        1'b0, 32'h4,        32'h08000000, 1'b0);
    // SLL uses only in_b[4:0] (0x23 -> 3)
    drive(32'h00209033, 32'h1,        32'h23,       1'b0, 32'h0,        32'h8,        1'b0);
    // SLT / SLTU with -1 vs 1
    drive(32'h0020A033, 32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        32'h1,        1'b0);
    drive(32'h0020B033, 32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        32'h0,        1'b0);
    // XOR / OR / AND
    drive(32'h0020C033, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0,        32'h0FF00FF0, 1'b0);
    drive(32'h0020E033, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0,        32'hFFF0FFF0, 1'b0);
    drive(32'h0020F033, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0,        32'hF000F000, 1'b0);
    // Branches with in_a=-1, in_b=1 (result is the wrapping sum, 0)
    drive(32'h00004063, 32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        32'h0,        1'b1); // BLT
    drive(32'h00006063, 32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        32'h0,        1'b0); // BLTU
    drive(32'h00005063, 32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        32'h0,        1'b0); // BGE
    drive(32'h00007063, 32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        32'h0,        1'b1); // BGEU
    drive(32'h00001063, 32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        32'h0,        1'b1); // BNE
    drive(32'h00002063, 32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        32'h0,        1'b0); // f3=010
    // BEQ taken with B-imm -4; first under reset (regs stay 0), then captured.
    drive(32'hFE000EE3, 32'h7,        32'h7,        1'b1, 32'hFFFFFFFC, 32'hE,        1'b1);
    drive(32'hFE000EE3, 32'h7,        32'h7,        1'b0, 32'hFFFFFFFC, 32'hE,        1'b1);
    // JAL link value, LUI, SW address, unknown opcode wrap, final NOP
    drive(32'h0080006F, 32'h100,      32'h4,        1'b0, 32'h8,        32'h104,      1'b0);
    drive(32'h123450B7, 32'h0,        32'h12345000, 1'b0, 32'h12345000, 32'h12345000, 1'b0);
    drive(32'hFE20AC23, 32'h100,      32'hFFFFFFF8, 1'b0, 32'hFFFFFFF8, 32'hF8,       1'b0);
    drive(32'h0000007F, 32'hFFFFFFFF, 32'h2,        1'b0, 32'h0,        32'h1,        1'b0);
    drive(NOP,          32'h1,        32'h1,        1'b0, 32'h0,        32'h2,        1'b0);

    @(negedge clk);
    drv_valid = 1'b0;

    // Bounded drain of the expectation queue.
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
